// File: rtl/mem_responder.sv
// Single-outstanding memory responder for the req/gnt/rvalid bus, backed by a byte-enable word array.
// Optional macro MEM_RESP_ERR_EN: flag out-of-range addresses with mem_error_o instead of aliasing.
module mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        mem_we_i,
  input  logic        mem_req_i,
  input  logic [3:0]  mem_be_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_gnt_o,
  output logic        mem_rvalid_o,
  output logic        mem_error_o
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned LOAD_INT = (LATENCY > 1) ? (LATENCY - 2) : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_INT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;

  logic [31:0]           mem_q [DEPTH];
  logic                  gnt_c;
  logic                  enter_resp_c;
  logic                  wr_en_c;
  logic [31:0]           acc_addr_c;
  logic [31:0]           acc_wdata_c;
  logic                  acc_we_c;
  logic [3:0]            acc_be_c;
  logic [31:0]           off_c;
  logic [DEPTH_LOG2-1:0] idx_c;
  logic                  oor_c;

  // Grant is combinational so a request in IDLE is accepted in the same cycle.
  assign gnt_c = (state_q == ST_IDLE) && mem_req_i && !reset;

  // On the LATENCY=1 grant edge the access uses the live request, otherwise the captured one.
  assign acc_addr_c  = (state_q == ST_IDLE) ? mem_addr_i  : addr_q;
  assign acc_wdata_c = (state_q == ST_IDLE) ? mem_wdata_i : wdata_q;
  assign acc_we_c    = (state_q == ST_IDLE) ? mem_we_i    : we_q;
  assign acc_be_c    = (state_q == ST_IDLE) ? mem_be_i    : be_q;

  assign off_c = acc_addr_c - BASE_ADDR;
  assign idx_c = off_c[DEPTH_LOG2+1:2];

  logic unused_off_lo;
  assign unused_off_lo = ^off_c[1:0];

`ifdef MEM_RESP_ERR_EN
  assign oor_c = |off_c[31:DEPTH_LOG2+2];
`else
  // Without error reporting, high offset bits are dropped and the access aliases.
  logic unused_off_hi;
  assign unused_off_hi = ^off_c[31:DEPTH_LOG2+2];
  assign oor_c = 1'b0;
`endif

  // Next-state, capture and response computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    be_d         = be_q;
    rdata_d      = '0;
    rvalid_d     = 1'b0;
    err_d        = 1'b0;
    enter_resp_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_c) begin
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          we_d    = mem_we_i;
          be_d    = mem_be_i;
          if (LATENCY == 1) begin
            state_d      = ST_RESP;
            enter_resp_c = 1'b1;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = ST_RESP;
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_resp_c) begin
      rvalid_d = 1'b1;
      if (oor_c) begin
        err_d = 1'b1;
      end else if (!acc_we_c) begin
        rdata_d = mem_q[idx_c];
      end
    end
  end

  assign wr_en_c = enter_resp_c && acc_we_c && !oor_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // Array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be_c[i]) begin
          mem_q[idx_c][8*i +: 8] <= acc_wdata_c[8*i +: 8];
        end
      end
    end
  end

  assign mem_gnt_o    = gnt_c;
  assign mem_rdata_o  = rdata_q;
  assign mem_rvalid_o = rvalid_q;
  assign mem_error_o  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver pushes expected responses, monitor pops and compares.
module tb_mem_responder;

  localparam int unsigned DL2   = 6;
  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 1 << DL2;
  localparam logic [31:0] BASE  = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_we_i;
  logic        mem_req_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_rdata_o;
  logic        mem_gnt_o;
  logic        mem_rvalid_o;
  logic        mem_error_o;

  mem_responder #(
    .DEPTH_LOG2(DL2),
    .LATENCY   (LAT),
    .BASE_ADDR (BASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_we_i    (mem_we_i),
    .mem_req_i   (mem_req_i),
    .mem_be_i    (mem_be_i),
    .mem_rdata_o (mem_rdata_o),
    .mem_gnt_o   (mem_gnt_o),
    .mem_rvalid_o(mem_rvalid_o),
    .mem_error_o (mem_error_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [DEPTH];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          last_g = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef MEM_RESP_ERR_EN
    logic [31:0] off;
    off = a - BASE;
    return off >= 32'(4 * DEPTH);
`else
    return (a != a);
`endif
  endfunction

  function automatic int unsigned word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off / 4) % DEPTH;
  endfunction

  // Issue one request; entered and left at posedge+1.
  task automatic do_txn(input logic [31:0] a, input bit w, input logic [31:0] d,
                        input logic [3:0] b, input bit abort);
    int   rise, want_g, gc;
    bit   got;
    exp_t e;
    int unsigned ix;
    rise   = cyc;
    want_g = (last_g + int'(LAT) + 1 > rise) ? last_g + int'(LAT) + 1 : rise;
    mem_req_i = 1'b1; mem_addr_i = a; mem_we_i = w; mem_wdata_i = d; mem_be_i = b;
    got = 1'b0; gc = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (mem_gnt_o) begin got = 1'b1; gc = cyc; end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL gnt_timeout: no grant for addr %h", a);
    end else begin
      check("gnt_cycle", 32'(gc), 32'(want_g));
      last_g = gc;
      if (!abort) begin
        e.due = gc + int'(LAT);
        e.err = 1'b0;
        e.rdata = '0;
        ix = word_idx(a);
        if (out_of_range(a)) begin
          e.err = 1'b1;
        end else if (w) begin
          for (int k = 0; k < 4; k++)
            if (b[k]) model[ix][8*k +: 8] = d[8*k +: 8];
        end else begin
          e.rdata = model[ix];
        end
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    mem_req_i = 1'b0;
  endtask

  // Monitor: during reset all outputs must be zero; otherwise each rvalid pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("reset_rvalid", 32'(mem_rvalid_o), 32'h0);
      check("reset_rdata",  mem_rdata_o,        32'h0);
      check("reset_error",  32'(mem_error_o),  32'h0);
      check("reset_gnt",    32'(mem_gnt_o),    32'h0);
    end else if (mem_rvalid_o) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_rvalid: rvalid at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = exp_q.pop_front();
        check("rvalid_cycle", 32'(cyc), 32'(e.due));
        check("rdata",        mem_rdata_o, e.rdata);
        check("error",        32'(mem_error_o), 32'(e.err));
      end
    end
  end

  initial begin
    logic [31:0] a;
    int gap;
    reset = 1'b1;
    mem_req_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0; mem_we_i = 1'b0; mem_be_i = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < int'(DEPTH); i++)
      do_txn(BASE + 32'(4 * i), 1'b1, $urandom, 4'hF, 1'b0);

    do_txn(BASE + 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0);
    do_txn(BASE + 32'h10, 1'b0, 32'h0, 4'h0, 1'b0);

    do_txn(BASE + 32'h20, 1'b1, 32'h1122_3344, 4'hF, 1'b0);
    do_txn(BASE + 32'h20, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b0);
    do_txn(BASE + 32'h20, 1'b0, 32'h0, 4'h0, 1'b0);
    check("be_merge_model", model[8], 32'h11BB_33DD);

    do_txn(BASE + 32'h24, 1'b1, 32'h55AA_55AA, 4'hF, 1'b0);
    do_txn(BASE + 32'h24, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b0);
    do_txn(BASE + 32'h24, 1'b0, 32'h0, 4'h0, 1'b0);

    do_txn(BASE + 32'(4 * DEPTH), 1'b0, 32'h0, 4'h0, 1'b0);
    do_txn(BASE - 32'h4, 1'b0, 32'h0, 4'h0, 1'b0);

    // Request raised and dropped while busy must never be granted.
    do_txn(BASE + 32'h40, 1'b0, 32'h0, 4'h0, 1'b0);
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = BASE + 32'h44;
    mem_wdata_i = 32'hFFFF_FFFF; mem_be_i = 4'hF;
    @(posedge clk); #1;
    mem_req_i = 1'b0;
    do_txn(BASE + 32'h44, 1'b0, 32'h0, 4'h0, 1'b0);

    // Reset while the write is still waiting: it must not commit or respond.
    do_txn(BASE + 32'h30, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1);
    reset = 1'b1;
    mem_req_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mem_req_i = 1'b0;
    last_g = -100;
    do_txn(BASE + 32'h30, 1'b0, 32'h0, 4'h0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0:       a = BASE + 32'($urandom_range(4 * DEPTH, 8 * DEPTH - 1));
        1:       a = BASE - 32'($urandom_range(1, 64));
        default: a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      endcase
      do_txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 1'b0);
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d responses never arrived", exp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core/cache req/gnt/rvalid bus; terminates the memory port of the data cache.
- Backed by a synchronous single-port word array with byte-enable writes and a configurable grant-to-response latency.
- Used as the on-chip data RAM behind the cache and as the memory model in cache testbenches.
- One outstanding transaction at a time.

Parameters:
- DEPTH_LOG2, 10, log2 of array depth in 32-bit words (default 1024 words = 4 KiB).
- LATENCY, 1, cycles from grant cycle to rvalid cycle; legal range 1..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*2^DEPTH_LOG2.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_addr_i  input  32  byte address; bits [1:0] ignored.
- mem_wdata_i  input  32  write data.
- mem_we_i  input  1  1 = write, 0 = read.
- mem_req_i  input  1  request; held by the initiator until granted.
- mem_be_i  input  4  byte enables; bit n covers wdata[8n+7:8n].
- mem_rdata_o  output  32  read data, valid only while mem_rvalid_o = 1.
- mem_gnt_o  output  1  grant; request accepted this cycle.
- mem_rvalid_o  output  1  one-cycle response strobe.
- mem_error_o  output  1  response error; qualified by mem_rvalid_o.

Behaviour:
- Reset (clk and reset as decided: reset asynchronous, active-high; clock clk):
  - State IDLE; counter 0; captured request registers 0.
  - mem_rdata_o = 0, mem_rvalid_o = 0, mem_error_o = 0; mem_gnt_o = 0 while reset is asserted.
  - Array contents are not reset (BRAM inference).
- States: IDLE, WAIT, RESP.
- IDLE:
  - mem_gnt_o = mem_req_i, combinational, no registered delay.
  - On a grant edge, capture addr, wdata, we and be.
  - LATENCY = 1: go to RESP. Otherwise load counter with LATENCY-2 and go to WAIT.
- WAIT:
  - mem_gnt_o = 0.
  - When counter = 0, go to RESP; otherwise decrement.
- Array access happens on the edge entering RESP:
  - Read: mem_rdata_o <= array[idx].
  - Write: each byte with be[n] = 1 is written; bytes with be[n] = 0 keep their old value; mem_rdata_o <= 0.
- RESP:
  - mem_rvalid_o = 1 for exactly one cycle; mem_gnt_o = 0; next state IDLE.
  - On exit, mem_rdata_o and mem_error_o return to 0.
- Timing:
  - Grant in cycle G gives rvalid in cycle G+LATENCY.
  - Earliest next grant is G+LATENCY+1.
  - Sustained throughput is one transaction per LATENCY+1 cycles.
- Index: idx = (mem_addr_i - BASE_ADDR)[DEPTH_LOG2+1:2]; the subtraction is 32-bit unsigned.
- be = 4'b0000 on a write: no byte is modified, response still issued.
- Request held high through RESP: it is not granted until IDLE; exactly one grant per accepted transaction.
- Initiator drops req before grant: no capture, nothing happens.
- Reset mid-transaction:
  - Asserted in WAIT or RESP: return to IDLE, no rvalid issued.
  - A write commits only if the edge entering RESP occurred before reset assertion.

Optional Feature:
- Macro MEM_RESP_ERR_EN.
- Defined:
  - An address with addr < BASE_ADDR, or addr - BASE_ADDR >= 4*2^DEPTH_LOG2, is out of range.
  - Out-of-range requests are still granted and follow normal latency.
  - No array access is made; the RESP cycle has mem_rdata_o = 0 and mem_error_o = 1.
- Undefined:
  - mem_error_o is tied to 0.
  - Out-of-range addresses alias via the low index bits; the access is performed on the aliased word.

Test Plan:
- Write then read, LATENCY=1: write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10. Each grant is in the req cycle, rvalid one cycle later, read rdata = 0xDEADBEEF.
- Byte enables: preload 0x11223344 at 0x20; write 0xAABBCCDD with be=4'b0101. A read returns 0x11BB33DD.
- Latency, LATENCY=3: req at cycle 0 gives gnt at 0, rvalid only at 3. With req held high continuously, the second gnt is at cycle 4; rvalid is never asserted for 2 consecutive cycles.
- Zero byte enable: write with be=0 to a word holding 0x55AA55AA. rvalid is still issued and a subsequent read returns 0x55AA55AA.
- Out of range, with MEM_RESP_ERR_EN, DEPTH_LOG2=10: read 0x0000_1000 gives rvalid=1, error=1, rdata=0. Without the macro, a read of 0x1000 returns the word at 0x0.
- Reset mid-WAIT, LATENCY=4: grant a write, assert reset at cycle 2. No rvalid is issued, a read after reset returns the old contents, and outputs are 0 during reset.
